// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions for the compression core and its message
// schedule: round constants K[0..63], the standard initial hash value, the
// word-level mixing functions, and the core's FSM state type.
package sha256_pkg;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // H0..H7, H0 in the most significant word.
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Sliding 16-word message schedule window. Slot 0 always holds W[t]; each
// advance shifts the window by one word and appends W[t+16].
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (window cleared)
//   load      : capture block (W0 in block[511:480]) into the window
//   advance   : shift the window by one word
//   block     : 512-bit message block
//   w_t       : current schedule word W[t]
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  logic [511:0] block,
    output logic [31:0]  w_t
);

    logic [31:0] win [16];
    logic [31:0] w_next;

    // With win[k] = W[t+k]: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign w_next = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
    assign w_t    = win[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
        end else if (advance) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
        end
    end

endmodule

// File: rtl/sha256_compress_core.sv
// sha256_compress_core
// Iterative SHA-256 compression: one 512-bit block plus a 256-bit chaining
// value in, updated chaining value out, one round per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and once out_valid is raised the
// digest is held stable until it is taken.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : block_in / chain_in / use_iv valid
//   in_ready    : core idle, block accepted on in_valid
//   block_in    : message block, W0 in [511:480]
//   chain_in    : incoming hash, H0 in [255:224]
//   use_iv      : 1 selects the standard IV instead of chain_in
//   out_valid   : digest_out valid
//   out_ready   : consumer takes digest_out
//   digest_out  : updated hash, H0 in [255:224]
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] chain_in,
    input  logic         use_iv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out
);

    state_t       state;
    logic [5:0]   t;
    logic [31:0]  h_init [8];
    logic [31:0]  wk [8];     // working registers, wk[0]=a .. wk[7]=h
    logic [31:0]  w_t;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] chain_sel;
    logic         accept;

    assign accept    = (state == ST_IDLE) && in_valid;
    assign chain_sel = use_iv ? IV : chain_in;

    assign t1 = wk[7] + big_sigma1(wk[4]) + ch(wk[4], wk[5], wk[6]) + K[t] + w_t;
    assign t2 = big_sigma0(wk[0]) + maj(wk[0], wk[1], wk[2]);

    sha256_msg_schedule u_sched (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (state == ST_ROUND),
        .block   (block_in),
        .w_t     (w_t)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            digest_out <= '0;
            t          <= '0;
            for (int i = 0; i < 8; i++) begin
                h_init[i] <= '0;
                wk[i]     <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            h_init[i] <= chain_sel[255 - 32*i -: 32];
                            wk[i]     <= chain_sel[255 - 32*i -: 32];
                        end
                        t        <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    wk[0] <= t1 + t2;
                    wk[1] <= wk[0];
                    wk[2] <= wk[1];
                    wk[3] <= wk[2];
                    wk[4] <= wk[3] + t1;
                    wk[5] <= wk[4];
                    wk[6] <= wk[5];
                    wk[7] <= wk[6];
                    // Counter stops at the last round rather than wrapping.
                    if (t == 6'(ROUNDS - 1)) state <= ST_FINAL;
                    else                     t     <= t + 6'd1;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++)
                        digest_out[255 - 32*i -: 32] <= h_init[i] + wk[i];
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress_core.sv
module tb_sha256_compress_core;
    import sha256_pkg::*;

    localparam int ROUNDS = 64;

    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    // 448-bit message with its 0x80 pad byte; the length lands in block 2.
    localparam logic [511:0] MB1_BLK = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MB2_BLK = {480'h0, 32'h000001c0};

    localparam logic [255:0] EMPTY_D =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] MB_D =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    // clock / reset
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] chain_in;
    logic         use_iv;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_compress_core #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .block_in   (block_in),
        .chain_in   (chain_in),
        .use_iv     (use_iv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .digest_out (digest_out)
    );

    // scoreboard state
    logic [255:0] exp_q[$];
    int           acc_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    int           last_hs_cyc = 0;
    int           last_acc = 0;
    int           mon_acc;
    logic         prev_valid = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    // reference model: straight from the SHA-256 definition
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] chain, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  hh [8];
        logic [31:0]  s0, s1, x1, x2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            hh[i] = chain[255 - 32*i -: 32];
            v[i]  = hh[i];
        end
        for (int r = 0; r < 64; r++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[r] + w[r];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // driver: present a block until accepted, then queue its expected digest
    task automatic send(input logic [511:0] blk, input logic [255:0] chain, input logic iv,
                        input logic [255:0] req);
        int waited;
        waited = 0;
        @(negedge clk);
        block_in = blk;
        chain_in = chain;
        use_iv   = iv;
        in_valid = 1'b1;
        while (!in_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(req);
        acc_q.push_back(cyc);
        last_acc = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size(), 0);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: latency on each out_valid rise, digest on each handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_valid) begin
                    if (acc_q.size() == 0) fail_now("unexpected_valid", 1, 0);
                    else begin
                        mon_acc = acc_q.pop_front();
                        check("latency", 256'(cyc - mon_acc), 256'(ROUNDS + 1));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_output", 1, 0);
                    else check("digest", digest_out, exp_q.pop_front());
                    last_hs_cyc = cyc + 1;
                end
            end
            prev_valid = rst ? 1'b0 : out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic [255:0] d1, held, ch_r;
        logic [511:0] blk_r;
        logic         iv_r;
        int           prev_acc;

        in_valid = 1'b0;
        block_in = '0;
        chain_in = '0;
        use_iv   = 1'b0;
        ready_mode = 1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 256'(in_ready), 256'(1));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_digest", digest_out, '0);
        rst = 1'b0;

        // known answers; random chain_in proves it is ignored with use_iv
        send(EMPTY_BLK, rand256(), 1'b1, EMPTY_D);
        send(ABC_BLK, rand256(), 1'b1, ABC_D);
        d1 = ref_compress(IV, MB1_BLK);
        send(MB1_BLK, rand256(), 1'b1, d1);
        send(MB2_BLK, d1, 1'b0, MB_D);
        wait_drain();

        // backpressure
        ready_mode = 0;
        repeat (2) @(negedge clk);
        send(ABC_BLK, '0, 1'b1, ABC_D);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) fail_now("bp_valid_timeout", 0, 1);
        end
        held = digest_out;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                block_in = EMPTY_BLK;
                use_iv   = 1'b1;
                in_valid = 1'b1;
            end
            if (i == 9) in_valid = 1'b0;
            check("bp_out_valid", 256'(out_valid), 256'(1));
            check("bp_digest_hold", digest_out, held);
            check("bp_in_ready", 256'(in_ready), 256'(0));
        end
        ready_mode = 1;
        send(EMPTY_BLK, rand256(), 1'b1, EMPTY_D);
        check("accept_after_handshake", 256'(last_acc), 256'(last_hs_cyc + 1));
        wait_drain();

        // reset in the middle of the rounds
        send(ABC_BLK, '0, 1'b1, ABC_D);
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_out_valid", 256'(out_valid), 256'(0));
        check("abort_in_ready", 256'(in_ready), 256'(1));
        check("abort_digest", digest_out, '0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(EMPTY_BLK, '0, 1'b1, EMPTY_D);
        wait_drain();

        // back-to-back throughput with out_ready high
        prev_acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) send(ABC_BLK, rand256(), 1'b1, ABC_D);
            else            send(EMPTY_BLK, rand256(), 1'b1, EMPTY_D);
            if (k > 0) check("throughput", 256'(last_acc - prev_acc), 256'(ROUNDS + 3));
            prev_acc = last_acc;
        end
        wait_drain();

        // random blocks and chaining values with random out_ready
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            blk_r = rand512();
            ch_r  = rand256();
            iv_r  = 1'($urandom_range(0, 1));
            send(blk_r, ch_r, iv_r, ref_compress(iv_r ? IV : ch_r, blk_r));
        end
        wait_drain();
        ready_mode = 1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_compress_core.md
Name: sha256_compress_core

Overview:
- Iterative SHA-256 compression engine: one 512-bit message block in, updated 256-bit hash state out, one round per clock.
- Sits directly downstream of the per-bit choose stage: Ch(e,f,g), Maj, Σ0/Σ1 and the message schedule are evaluated here each round, and the round result feeds the working registers a..h.
- The mining datapath uses it for midstate, second-block and double-hash passes.

Parameters:
- ROUNDS, 64, number of compression rounds. Fixed at 64 for SHA-256; exists only to shorten rounds in simulation.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, block_in/chain_in/use_iv valid.
- in_ready, output, 1, core is idle and accepts a block.
- block_in, input, 512, message block; [511:480]=W0 … [31:0]=W15, big-endian words.
- chain_in, input, 256, incoming hash state; [255:224]=H0 … [31:0]=H7.
- use_iv, input, 1, 1: ignore chain_in and use the standard SHA-256 IV.
- out_valid, output, 1, digest_out valid.
- out_ready, input, 1, consumer accepts digest_out.
- digest_out, output, 256, updated hash state; same word order as chain_in.

Behaviour:
- Reset is asynchronous, active-high, on rst. While rst is high and after it falls:
  - state=IDLE, in_ready=1, out_valid=0, digest_out=0.
  - Round counter=0; working registers and schedule window are zero.
- States and transitions:
  - IDLE → ROUND on in_valid&&in_ready. The same edge latches:
    - H0..H7 = use_iv ? IV : chain_in;
    - a..h = the same value;
    - the 16-word schedule window = block_in;
    - round counter t=0.
  - ROUND: one round per edge.
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
    - T2 = Σ0(a) + Maj(a,b,c).
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
    - All additions are mod 2^32; carries are discarded.
    - W[t] for t<16 is the window head. For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window shifts by one word per round.
    - After the round with t=ROUNDS-1, go to FINAL.
  - FINAL: one edge.
    - digest_out = {H0+a, …, H7+h}, each mod 2^32.
    - out_valid←1; go to DONE.
  - DONE: hold digest_out and out_valid stable until out_valid&&out_ready, then go to IDLE with out_valid←0 and in_ready←1.
- Latency: acceptance on edge A; out_valid is high after edge A+ROUNDS+1, i.e. 65 cycles at default.
- in_ready=1 only in IDLE. in_valid is ignored in ROUND, FINAL and DONE; there is no overlap of blocks.
- out_ready asserted outside DONE has no effect.
- If out_ready is held high, the earliest next acceptance is the cycle after the DONE→IDLE edge.
- digest_out keeps its last value after the handshake until the next FINAL.
- rst mid-ROUND or mid-DONE aborts the operation: the partial result is discarded and no out_valid is produced.
- The round counter wraps at no point; it is cleared on each acceptance.

Decomposition:
- Shared package sha256_pkg holds:
  - K[0..63] round-constant array;
  - IV H0..H7 constants;
  - functions Σ0, Σ1, σ0, σ1, Ch, Maj on 32-bit words.
- One natural sub-module: sha256_msg_schedule. It contains the 16×32 window and produces W[t], with load, advance and W_t ports.
- The round logic, FSM and final addition stay in the core.

Test Plan:
1. Empty message, single block:
   - Stimulus: block_in=0x80000000 followed by zeros, use_iv=1.
   - Response: digest_out=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with out_valid exactly 65 cycles after acceptance.
2. "abc", single block:
   - Stimulus: block_in=0x61626380, zeros, last word 0x00000018, use_iv=1.
   - Response: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
3. Two-block chaining:
   - Stimulus: the 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" message. First block uses use_iv=1. Second block (0x80000000, zeros, length 0x000001c0) uses use_iv=0 and chain_in = first digest.
   - Response: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. Backpressure:
   - Stimulus: hold out_ready=0 for 20 cycles after out_valid; pulse in_valid with a new block during that time.
   - Response: digest_out and out_valid are stable; in_ready=0; the new block is not accepted. Acceptance happens one cycle after the out_ready handshake.
5. Reset mid-operation:
   - Stimulus: assert rst asynchronously at round 30 of the "abc" block, then release it and resubmit the empty-message block.
   - Response: out_valid=0 and in_ready=1 immediately. Only the empty-message digest is produced, with no stale "abc" output.
6. Back-to-back throughput:
   - Stimulus: out_ready tied to 1; in_valid held high with alternating "abc" and empty blocks.
   - Response: correct digests in order; one acceptance every 67 cycles.
